// File: rtl/dg_pkg.sv
// Shared types and defaults for the pattern engine: pattern modes, FSM states,
// default bus widths and the bench clock period.
package dg_pkg;

    typedef enum logic [2:0] {
        PAT_FIXED = 3'd0,
        PAT_INCR  = 3'd1,
        PAT_WALK1 = 3'd2,
        PAT_ALT   = 3'd3,
        PAT_LFSR  = 3'd4
    } pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int PATTERN_DATA_WIDTH_DEF = 32;
    localparam int C_AXI_DATA_WIDTH_DEF   = 128;
    localparam int CLK_PERIOD             = 10;

endpackage

// File: rtl/dg_pattern_step.sv
// Combinational pattern stepping: produces the word that follows `word` in
// the selected mode, and sanitises a seed (walking-one and LFSR cannot
// start from zero, so a zero seed becomes 1). Reserved modes hold the word.
module dg_pattern_step
    import dg_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] word,
    input  logic [2:0]       seed_mode,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] next_word,
    output logic [WIDTH-1:0] seed_word
);

    // Next word of the pattern sequence for the current mode.
    always_comb begin
        // NOTE: assign a default before the case so every path drives the output and no latch is inferred.
        next_word = word;
        case (pattern_t'(mode))
            PAT_INCR:  next_word = word + WIDTH'(1);
            PAT_WALK1: next_word = {word[WIDTH-2:0], word[WIDTH-1]};
            PAT_ALT:   next_word = ~word;
            PAT_LFSR:  next_word = (word >> 1) ^ (word[0] ? TAPS : '0);
            default:   next_word = word;
        endcase
    end

    // Seed clean-up applied when the pattern is (re)initialised.
    always_comb begin
        seed_word = seed_in;
        if (((pattern_t'(seed_mode) == PAT_WALK1) || (pattern_t'(seed_mode) == PAT_LFSR))
            && (seed_in == '0)) begin
            seed_word = WIDTH'(1);
        end
    end

endmodule

// File: rtl/dg_pattern_engine.sv
// Pattern generator/checker. Emits a replicated pattern word on data_o while
// data_en is high and checks returned rdata (byte-masked) against an
// independently advanced expected copy, keeping saturating word/error counts
// and a sticky mismatch flag.
// Optional: define DG_ERR_INJECT_EN to add the err_inject input, which flips
// bit 0 of data_o for the beat generated while it is high.
module dg_pattern_engine
    import dg_pkg::*;
#(
    parameter int          PATTERN_DATA_WIDTH = PATTERN_DATA_WIDTH_DEF,
    parameter int          C_AXI_DATA_WIDTH   = C_AXI_DATA_WIDTH_DEF,
    parameter int          CNT_WIDTH          = 8,
    parameter logic [31:0] LFSR_TAPS          = 32'h8020_0003
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pattern_init,
    input  logic [2:0]                      pattern_mode,
    input  logic [PATTERN_DATA_WIDTH-1:0]   pattern_word,
    input  logic                            data_en,
    output logic [C_AXI_DATA_WIDTH-1:0]     data_o,
    output logic                            data_vld,
    input  logic [C_AXI_DATA_WIDTH-1:0]     rdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   rdata_bvld,
    input  logic                            rdata_vld,
    input  logic                            wrd_cntr_rst,
    output logic [CNT_WIDTH-1:0]            wrd_cntr,
    output logic [CNT_WIDTH-1:0]            err_cntr,
    output logic                            msmatch_err,
`ifdef DG_ERR_INJECT_EN
    input  logic                            err_inject,
`endif
    output logic                            busy
);

    localparam int NUM_REP   = C_AXI_DATA_WIDTH / PATTERN_DATA_WIDTH;
    localparam int NUM_BYTES = C_AXI_DATA_WIDTH / 8;
    localparam logic [PATTERN_DATA_WIDTH-1:0] TAPS_W = PATTERN_DATA_WIDTH'(LFSR_TAPS);

    state_t                          state_q, state_d;
    pattern_t                        mode_q;
    logic [PATTERN_DATA_WIDTH-1:0]   gen_word, gen_next, gen_seed;
    logic [PATTERN_DATA_WIDTH-1:0]   exp_word, exp_next, exp_seed;
    logic [C_AXI_DATA_WIDTH-1:0]     exp_beat;
    logic [C_AXI_DATA_WIDTH-1:0]     inj_mask;
    logic [NUM_BYTES-1:0]            byte_miss;
    logic                            beat_bad;
    logic                            gen_fire;
    logic                            chk_fire;

    // Beats are only produced or checked once a pattern has been armed;
    // pattern_init takes priority in the sequential blocks below.
    assign gen_fire = data_en   && (state_q != ST_IDLE);
    assign chk_fire = rdata_vld && (state_q != ST_IDLE);
    assign busy     = (state_q == ST_RUN);
    assign exp_beat = {NUM_REP{exp_word}};
    assign beat_bad = |byte_miss;

`ifdef DG_ERR_INJECT_EN
    assign inj_mask = {{(C_AXI_DATA_WIDTH-1){1'b0}}, err_inject};
`else
    assign inj_mask = '0;
`endif

    dg_pattern_step #(.WIDTH(PATTERN_DATA_WIDTH), .TAPS(TAPS_W)) u_gen_step (
        .mode      (mode_q),
        .word      (gen_word),
        .seed_mode (pattern_mode),
        .seed_in   (pattern_word),
        .next_word (gen_next),
        .seed_word (gen_seed)
    );

    dg_pattern_step #(.WIDTH(PATTERN_DATA_WIDTH), .TAPS(TAPS_W)) u_exp_step (
        .mode      (mode_q),
        .word      (exp_word),
        .seed_mode (pattern_mode),
        .seed_in   (pattern_word),
        .next_word (exp_next),
        .seed_word (exp_seed)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: init re-arms from anywhere, data_en toggles ARMED/RUN.
    always_comb begin
        state_d = state_q;
        if (pattern_init) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_ARMED: if (data_en)  state_d = ST_RUN;
                ST_RUN:   if (!data_en) state_d = ST_ARMED;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Generator: latch mode/seed on init, otherwise emit and advance per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= PAT_FIXED;
            gen_word <= '0;
            data_o   <= '0;
            data_vld <= 1'b0;
        end else if (pattern_init) begin
            mode_q   <= pattern_t'(pattern_mode);
            gen_word <= gen_seed;
            data_vld <= 1'b0;
        end else begin
            data_vld <= gen_fire;
            if (gen_fire) begin
                data_o   <= {NUM_REP{gen_word}} ^ inj_mask;
                gen_word <= gen_next;
            end
        end
    end

    // Per-byte compare of the returned beat, masked by rdata_bvld.
    always_comb begin
        byte_miss = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            byte_miss[i] = rdata_bvld[i] && (rdata[8*i +: 8] != exp_beat[8*i +: 8]);
        end
    end

    // Checker: advance expected word per accepted beat, update counters/flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_word    <= '0;
            wrd_cntr    <= '0;
            err_cntr    <= '0;
            msmatch_err <= 1'b0;
        end else if (pattern_init) begin
            exp_word    <= exp_seed;
            wrd_cntr    <= '0;
            err_cntr    <= '0;
            msmatch_err <= 1'b0;
        end else begin
            if (chk_fire) begin
                exp_word <= exp_next;
                if (beat_bad) begin
                    msmatch_err <= 1'b1;
                    if (err_cntr != '1) err_cntr <= err_cntr + CNT_WIDTH'(1);
                end
            end
            if (wrd_cntr_rst)                      wrd_cntr <= '0;
            else if (chk_fire && (wrd_cntr != '1)) wrd_cntr <= wrd_cntr + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dg_pattern_engine.sv
// Self-checking bench for dg_pattern_engine: a behavioural model tracks the
// expected outputs cycle by cycle, directed scenarios pin the model with
// literal values, and a randomized phase exercises modes, masks and controls.
module tb_dg_pattern_engine;
    import dg_pkg::*;

    localparam int PW      = 32;
    localparam int DW      = 128;
    localparam int NB      = DW / 8;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pattern_init;
    logic [2:0]    pattern_mode;
    logic [PW-1:0] pattern_word;
    logic          data_en;
    logic [DW-1:0] data_o;
    logic          data_vld;
    logic [DW-1:0] rdata;
    logic [NB-1:0] rdata_bvld;
    logic          rdata_vld;
    logic          wrd_cntr_rst;
    logic [CW-1:0] wrd_cntr;
    logic [CW-1:0] err_cntr;
    logic          msmatch_err;
    logic          busy;
`ifdef DG_ERR_INJECT_EN
    logic          err_inject;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #(CLK_PERIOD / 2) clk = ~clk;

    dg_pattern_engine #(
        .PATTERN_DATA_WIDTH (PW),
        .C_AXI_DATA_WIDTH   (DW),
        .CNT_WIDTH          (CW),
        .LFSR_TAPS          (32'h8020_0003)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pattern_init (pattern_init),
        .pattern_mode (pattern_mode),
        .pattern_word (pattern_word),
        .data_en      (data_en),
        .data_o       (data_o),
        .data_vld     (data_vld),
        .rdata        (rdata),
        .rdata_bvld   (rdata_bvld),
        .rdata_vld    (rdata_vld),
        .wrd_cntr_rst (wrd_cntr_rst),
        .wrd_cntr     (wrd_cntr),
        .err_cntr     (err_cntr),
        .msmatch_err  (msmatch_err),
`ifdef DG_ERR_INJECT_EN
        .err_inject   (err_inject),
`endif
        .busy         (busy)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [PW-1:0] m_step(input logic [2:0] mode, input logic [PW-1:0] w);
        case (mode)
            3'd1:    return w + 32'd1;
            3'd2:    return (w << 1) | (w >> (PW - 1));
            3'd3:    return ~w;
            3'd4:    return (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'd0);
            default: return w;
        endcase
    endfunction

    function automatic logic [PW-1:0] m_seed(input logic [2:0] mode, input logic [PW-1:0] w);
        if ((mode == 3'd2 || mode == 3'd4) && w == '0) return 32'd1;
        return w;
    endfunction

    function automatic logic [DW-1:0] rep(input logic [PW-1:0] w);
        return {(DW / PW){w}};
    endfunction

    function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] b);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{b[i]}};
        return m;
    endfunction

    logic [PW-1:0] m_gen  = '0;
    logic [PW-1:0] m_exp  = '0;
    logic [2:0]    m_mode = 3'd0;
    logic [DW-1:0] m_data = '0;
    bit            m_active = 1'b0;
    bit            m_busy   = 1'b0;
    bit            m_vld    = 1'b0;
    bit            m_mis    = 1'b0;
    int            m_wrd    = 0;
    int            m_err    = 0;

    initial begin
        logic [DW-1:0] inj;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_gen = '0; m_exp = '0; m_mode = 3'd0; m_data = '0;
                m_active = 1'b0; m_busy = 1'b0; m_vld = 1'b0; m_mis = 1'b0;
                m_wrd = 0; m_err = 0;
            end else if (pattern_init) begin
                m_mode   = pattern_mode;
                m_gen    = m_seed(pattern_mode, pattern_word);
                m_exp    = m_gen;
                m_active = 1'b1;
                m_busy   = 1'b0;
                m_vld    = 1'b0;
                m_mis    = 1'b0;
                m_wrd    = 0;
                m_err    = 0;
            end else begin
                inj = '0;
`ifdef DG_ERR_INJECT_EN
                inj[0] = err_inject;
`endif
                m_vld  = m_active && data_en;
                m_busy = m_active && data_en;
                if (m_vld) begin
                    m_data = rep(m_gen) ^ inj;
                    m_gen  = m_step(m_mode, m_gen);
                end
                if (m_active && rdata_vld) begin
                    if (((rdata ^ rep(m_exp)) & byte_mask(rdata_bvld)) != '0) begin
                        m_mis = 1'b1;
                        if (m_err < CNT_MAX) m_err++;
                    end
                    m_exp = m_step(m_mode, m_exp);
                    if (wrd_cntr_rst)         m_wrd = 0;
                    else if (m_wrd < CNT_MAX) m_wrd++;
                end else if (wrd_cntr_rst) begin
                    m_wrd = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_data_vld", DW'(data_vld),    DW'(m_vld));
                check("cyc_data_o",   data_o,           m_data);
                check("cyc_busy",     DW'(busy),        DW'(m_busy));
                check("cyc_wrd_cntr", DW'(wrd_cntr),    DW'(m_wrd));
                check("cyc_err_cntr", DW'(err_cntr),    DW'(m_err));
                check("cyc_msmatch",  DW'(msmatch_err), DW'(m_mis));
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PW-1:0] exp_incr [4];
        logic [PW-1:0] w;
        logic [DW-1:0] flip;

        rst = 1'b0; pattern_init = 1'b0; pattern_mode = 3'd0; pattern_word = '0;
        data_en = 1'b0; rdata = '0; rdata_bvld = '0; rdata_vld = 1'b0; wrd_cntr_rst = 1'b0;
`ifdef DG_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        #1 rst = 1'b1;
        repeat (2) nxt();
        check("rst_data_o",   data_o, '0);
        check("rst_data_vld", DW'(data_vld), '0);
        check("rst_busy",     DW'(busy), '0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // IDLE ignores data_en and rdata_vld.
        data_en = 1'b1; rdata_vld = 1'b1; rdata_bvld = '1; rdata = '1;
        repeat (2) nxt();
        check("idle_no_vld", DW'(data_vld), '0);
        check("idle_no_cnt", DW'(wrd_cntr), '0);
        data_en = 1'b0; rdata_vld = 1'b0;

        // INCR wrap.
        exp_incr[0] = 32'hFFFF_FFFE; exp_incr[1] = 32'hFFFF_FFFF;
        exp_incr[2] = 32'h0000_0000; exp_incr[3] = 32'h0000_0001;
        pattern_init = 1'b1; pattern_mode = 3'd1; pattern_word = 32'hFFFF_FFFE;
        nxt();
        pattern_init = 1'b0; data_en = 1'b1;
        nxt();
        check("incr_vld_lat", DW'(data_vld), DW'(1));
        check("incr_word0",   data_o, rep(exp_incr[0]));
        for (int i = 1; i < 4; i++) begin
            nxt();
            check("incr_word", DW'(data_o[PW-1:0]), DW'(exp_incr[i]));
            if (i == 3) data_en = 1'b0;
        end
        nxt();
        check("incr_vld_drop", DW'(data_vld), '0);
        check("incr_hold",     DW'(data_o[PW-1:0]), DW'(32'h0000_0001));

        // LFSR loopback, zero seed.
        pattern_init = 1'b1; pattern_mode = 3'd4; pattern_word = '0; rdata_bvld = '1;
        nxt();
        pattern_init = 1'b0; data_en = 1'b1;
        for (int i = 0; i < 22; i++) begin
            nxt();
            if (i == 0) check("lfsr_first", DW'(data_o[PW-1:0]), DW'(1));
            if (i == 1) check("lfsr_second", DW'(data_o[PW-1:0]), DW'(32'h8020_0003));
            rdata = data_o; rdata_vld = data_vld;
            if (i == 19) data_en = 1'b0;
        end
        check("lfsr_wrd", DW'(wrd_cntr), DW'(20));
        check("lfsr_err", DW'(err_cntr), '0);
        check("lfsr_mis", DW'(msmatch_err), '0);

        // WALK1, byte 5 corrupted on beat 3: masked then unmasked.
        for (int pass = 0; pass < 2; pass++) begin
            nxt();
            pattern_init = 1'b1; pattern_mode = 3'd2; pattern_word = 32'h8000_0000; rdata_vld = 1'b0;
            w = 32'h8000_0000;
            for (int b = 1; b <= 4; b++) begin
                nxt();
                if (b == 4) begin
                    check("walk_mis_1cyc", DW'(msmatch_err), DW'(pass));
                    check("walk_err_1cyc", DW'(err_cntr),    DW'(pass));
                end
                if (b == 3) check("walk_mis_pre", DW'(msmatch_err), '0);
                pattern_init = 1'b0;
                rdata = rep(w);
                if (b == 3) rdata = rdata ^ (DW'(8'hFF) << 40);
                rdata_bvld = (pass == 0) ? 16'hFFDF : 16'hFFFF;
                rdata_vld = 1'b1;
                w = {w[PW-2:0], w[PW-1]};
            end
            nxt();
            rdata_vld = 1'b0;
            check("walk_err_final", DW'(err_cntr), DW'(pass));
        end

        // Saturation, wrd_cntr_rst with a beat, init clears the flag.
        nxt();
        pattern_init = 1'b1; pattern_mode = 3'd0; pattern_word = 32'h1234_5678; rdata_bvld = '1;
        for (int i = 0; i < 300; i++) begin
            nxt();
            pattern_init = 1'b0; rdata = rep(32'h1234_5678); rdata_vld = 1'b1;
        end
        nxt();
        check("sat_wrd", DW'(wrd_cntr), DW'(255));
        check("sat_err", DW'(err_cntr), '0);
        rdata = ~rep(32'h1234_5678);
        nxt();
        check("bad_err", DW'(err_cntr), DW'(1));
        check("bad_mis", DW'(msmatch_err), DW'(1));
        rdata = rep(32'h1234_5678); wrd_cntr_rst = 1'b1;
        nxt();
        check("wrst_wrd", DW'(wrd_cntr), '0);
        check("wrst_err", DW'(err_cntr), DW'(1));
        wrd_cntr_rst = 1'b0; rdata_vld = 1'b0; pattern_init = 1'b1;
        nxt();
        pattern_init = 1'b0;
        check("init_clr_mis", DW'(msmatch_err), '0);
        check("init_clr_err", DW'(err_cntr), '0);

        // Asynchronous reset in RUN.
        pattern_init = 1'b1; pattern_mode = 3'd1; pattern_word = $urandom;
        nxt();
        pattern_init = 1'b0; data_en = 1'b1;
        repeat (3) nxt();
        check("run_busy", DW'(busy), DW'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_data_o",   data_o, '0);
        check("arst_data_vld", DW'(data_vld), '0);
        check("arst_busy",     DW'(busy), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            nxt();
            check("post_rst_no_vld", DW'(data_vld), '0);
        end
        data_en = 1'b0;

        // Randomized phase.
        for (int blk = 0; blk < 8; blk++) begin
            nxt();
            pattern_init = 1'b1;
            pattern_mode = 3'($urandom_range(0, 7));
            pattern_word = (blk % 3 == 0) ? 32'd0 : $urandom;
            data_en = 1'($urandom_range(0, 1));
            rdata_vld = 1'($urandom_range(0, 1));
            for (int c = 0; c < 300; c++) begin
                nxt();
                pattern_init = ($urandom_range(0, 99) == 0);
                if (pattern_init) begin
                    pattern_mode = 3'($urandom_range(0, 7));
                    pattern_word = $urandom;
                end
                data_en      = ($urandom_range(0, 3) != 0);
                rdata_vld    = 1'($urandom_range(0, 1));
                rdata_bvld   = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
                flip         = ($urandom_range(0, 15) == 0) ? (DW'(1) << $urandom_range(0, DW - 1)) : '0;
                rdata        = rep(m_exp) ^ flip;
                wrd_cntr_rst = ($urandom_range(0, 31) == 0);
            end
        end
        nxt();
        pattern_init = 1'b0; data_en = 1'b0; rdata_vld = 1'b0; wrd_cntr_rst = 1'b0;

`ifdef DG_ERR_INJECT_EN
        // Error injection on beat 2 of an ALT loopback.
        nxt();
        pattern_init = 1'b1; pattern_mode = 3'd3; pattern_word = 32'hA5A5_0F0F; rdata_bvld = '1;
        nxt();
        pattern_init = 1'b0; data_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nxt();
            err_inject = (i == 0);
            if (i == 1) check("inject_word", DW'(data_o[PW-1:0]), DW'(32'h5A5A_F0F1));
            if (i == 2) check("inject_clean", DW'(data_o[PW-1:0]), DW'(32'hA5A5_0F0F));
            rdata = data_o; rdata_vld = data_vld;
            if (i == 5) data_en = 1'b0;
        end
        check("inject_err", DW'(err_cntr), DW'(1));
        check("inject_mis", DW'(msmatch_err), DW'(1));
`endif

        nxt();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
